diff_accumulator_16: RTL

Downstream consumer of the 16-bit subtractor stage. It takes a stream of two's-complement differences through a valid/ready handshake and accumulates them into a wider signed sum. The sum saturates instead of wrapping. After COUNT_MAX samples, or on an early flush, it presents the frame result on a valid/ready output port.

---
 rtl/diff_accumulator_16.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/diff_accumulator_16.sv
// diff_accumulator_16
//   Collects a stream of signed differences from the subtractor stage into a
//   frame sum. The sum saturates at the ACC_WIDTH signed range and does not
//   wrap. A frame closes after COUNT_MAX samples, or earlier on flush. The
//   result is then held on a valid/ready output port until it is taken.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides all other inputs
//   in_valid   upstream difference valid
//   in_ready   block can accept a difference (low only while a result is held)
//   in_diff    signed difference, WIDTH bits
//   flush      close the current non-empty frame early
//   out_valid  frame result valid
//   out_ready  downstream accepts the result
//   out_sum    signed saturated frame sum, ACC_WIDTH bits
//   out_count  number of samples in the frame
//   out_ovf    saturation occurred somewhere in the frame
//   busy       frame in progress or result pending
//
// State  | meaning
// -------+-----------------------------------------------
// IDLE   | no samples in the current frame
// ACCUM  | 0 < count < COUNT_MAX, collecting samples
// HOLD   | result presented, input blocked until taken

module diff_accumulator_16 #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int COUNT_MAX = 8,
  localparam int CNT_W    = $clog2(COUNT_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_diff,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(COUNT_MAX);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 accept;
  logic                 close_frame;
  logic [CNT_W-1:0]     count_inc;
  logic [ACC_WIDTH:0]   diff_ext;
  logic [ACC_WIDTH:0]   acc_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] sat_sum;
  logic                 sat_hit;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  assign accept    = in_valid & in_ready;
  assign count_inc = count_q + CNT_W'(1);

  // One guard bit above the accumulator: the sum of two ACC_WIDTH-range values
  // always fits, and the two top bits disagreeing means the result left range.
  assign diff_ext = {{(ACC_WIDTH + 1 - WIDTH){in_diff[WIDTH-1]}}, in_diff};
  assign acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
  assign sum_ext  = acc_ext + diff_ext;

  always_comb begin
    sat_hit = 1'b0;
    sat_sum = sum_ext[ACC_WIDTH-1:0];
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
      sat_hit = 1'b1;
      sat_sum = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    close_frame = 1'b0;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = sat_sum;
          ovf_d   = ovf_q | sat_hit;
          count_d = count_inc;
        end
        // flush only closes a non-empty frame; a sample arriving on the same
        // edge is already folded into acc_d/count_d above.
        close_frame = (accept && (count_inc == CNT_LAST)) ||
                      ((state_q == ACCUM) && flush);
        if (close_frame) begin
          state_d     = HOLD;
          out_sum_d   = acc_d;
          out_count_d = count_d;
          out_ovf_d   = ovf_d;
        end else if (accept) begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
